// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the EX-stage divide issue controller, decode, the
// iterative divider and writeback. master = controller side, slave = environment side.
interface div_issue_ctrl_if #(
   parameter int XLEN = 32,
   parameter int RDW  = 5
);
   logic            ex_valid;
   logic            ex_ready;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_rs1;
   logic [XLEN-1:0] ex_rs2;
   logic [RDW-1:0]  ex_rd;
   logic            flush;

   logic            diven_p;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divider;
   logic            divsigned;
   logic            div_done;
   logic [XLEN-1:0] div_quot;
   logic [XLEN-1:0] div_rem;

   logic            wb_valid;
   logic            wb_ready;
   logic [XLEN-1:0] wb_data;
   logic [RDW-1:0]  wb_rd;
   logic            busy;

   modport master (
      input  ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_rd, flush,
      input  div_done, div_quot, div_rem, wb_ready,
      output ex_ready, diven_p, dividend, divider, divsigned,
      output wb_valid, wb_data, wb_rd, busy
   );

   modport slave (
      output ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_rd, flush,
      output div_done, div_quot, div_rem, wb_ready,
      input  ex_ready, diven_p, dividend, divider, divsigned,
      input  wb_valid, wb_data, wb_rd, busy
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage requester for the iterative divider: accepts DIV/DIVU/REM/REMU, launches the
// divider, returns quotient/remainder to writeback. Optional macro DIV_SPECIAL_BYPASS_EN.
module div_issue_ctrl #(
   parameter int XLEN = 32,
   parameter int RDW  = 5
) (
   input logic              clk,
   input logic              cpurst_n,
   div_issue_ctrl_if.master dif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_BUSY,
      ST_RESP,
      ST_DRAIN
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] dividend_q, dividend_d;
   logic [XLEN-1:0] divider_q, divider_d;
   logic            divsigned_q, divsigned_d;
   logic            sel_rem_q, sel_rem_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic [RDW-1:0]  wb_rd_q, wb_rd_d;
   logic            diven_p_q;
   logic            wb_valid_q;
   logic            busy_q;

   logic op_is_md;
   logic op_signed;
   logic op_rem;
   logic accept;

   // funct3 values outside the M-extension divide group fall back to DIVU
   assign op_is_md  = dif.ex_funct3[2];
   assign op_signed = op_is_md && !dif.ex_funct3[0];
   assign op_rem    = op_is_md && dif.ex_funct3[1];

   assign dif.ex_ready = (state_q == ST_IDLE) && !dif.flush;
   assign accept       = dif.ex_valid && dif.ex_ready;

`ifdef DIV_SPECIAL_BYPASS_EN
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic            div_by_zero;
   logic            signed_ovf;
   logic            is_special;
   logic [XLEN-1:0] special_res;

   assign div_by_zero = (dif.ex_rs2 == '0);
   assign signed_ovf  = op_signed && (dif.ex_rs1 == INT_MIN) && (dif.ex_rs2 == '1);
   assign is_special  = div_by_zero || signed_ovf;
   assign special_res = div_by_zero ? (op_rem ? dif.ex_rs1 : '1)
                                    : (op_rem ? '0 : INT_MIN);
`endif

   always_comb begin
      state_d     = state_q;
      dividend_d  = dividend_q;
      divider_d   = divider_q;
      divsigned_d = divsigned_q;
      sel_rem_d   = sel_rem_q;
      wb_data_d   = wb_data_q;
      wb_rd_d     = wb_rd_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               dividend_d  = dif.ex_rs1;
               divider_d   = dif.ex_rs2;
               divsigned_d = op_signed;
               sel_rem_d   = op_rem;
               wb_rd_d     = dif.ex_rd;
               state_d     = ST_LAUNCH;
`ifdef DIV_SPECIAL_BYPASS_EN
               if (is_special) begin
                  wb_data_d = special_res;
                  state_d   = ST_RESP;
               end
`endif
            end
         end

         // The start pulse already goes out this cycle, so a flush must still wait it out
         ST_LAUNCH: begin
            state_d = dif.flush ? ST_DRAIN : ST_BUSY;
         end

         ST_BUSY: begin
            if (dif.div_done) begin
               if (dif.flush) begin
                  state_d = ST_IDLE;
               end else begin
                  wb_data_d = sel_rem_q ? dif.div_rem : dif.div_quot;
                  state_d   = ST_RESP;
               end
            end else if (dif.flush) begin
               state_d = ST_DRAIN;
            end
         end

         // flush wins over a simultaneous wb_ready: the result is dropped
         ST_RESP: begin
            if (dif.flush || dif.wb_ready) begin
               state_d = ST_IDLE;
            end
         end

         ST_DRAIN: begin
            if (dif.div_done) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         state_q     <= ST_IDLE;
         dividend_q  <= '0;
         divider_q   <= '0;
         divsigned_q <= 1'b0;
         sel_rem_q   <= 1'b0;
         wb_data_q   <= '0;
         wb_rd_q     <= '0;
         diven_p_q   <= 1'b0;
         wb_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dividend_q  <= dividend_d;
         divider_q   <= divider_d;
         divsigned_q <= divsigned_d;
         sel_rem_q   <= sel_rem_d;
         wb_data_q   <= wb_data_d;
         wb_rd_q     <= wb_rd_d;
         // Status outputs are decoded from the next state so they are registered
         diven_p_q   <= (state_d == ST_LAUNCH);
         wb_valid_q  <= (state_d == ST_RESP);
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign dif.diven_p   = diven_p_q;
   assign dif.dividend  = dividend_q;
   assign dif.divider   = divider_q;
   assign dif.divsigned = divsigned_q;
   assign dif.wb_valid  = wb_valid_q;
   assign dif.wb_data   = wb_data_q;
   assign dif.wb_rd     = wb_rd_q;
   assign dif.busy      = busy_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: divider model, random and directed ops,
// monitor pops expected writeback results computed from RISC-V divide semantics.
module tb_div_issue_ctrl;
   localparam int XLEN = 32;
   localparam int RDW  = 5;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
   } exp_t;

   logic clk = 1'b0;
   logic cpurst_n = 1'b0;
   always #5 clk = ~clk;

   div_issue_ctrl_if #(.XLEN(XLEN), .RDW(RDW)) dif ();

   div_issue_ctrl #(.XLEN(XLEN), .RDW(RDW)) dut (
      .clk      (clk),
      .cpurst_n (cpurst_n),
      .dif      (dif)
   );

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   div_lat = 4;
   int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
   int   launch_cnt = 0;
   logic launch_signed = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting, expected event at %0t", name, $time);
   endtask

   // Architectural RISC-V divide result
   function automatic void ref_divide(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sgn) begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] q, r;
      logic sgn, rem;
      sgn = (f3 == 3'b100) || (f3 == 3'b110);
      rem = (f3 == 3'b110) || (f3 == 3'b111);
      ref_divide(sgn, a, b, q, r);
      return rem ? r : q;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Iterative divider model: fixed latency per launch, garbage on the result bus otherwise
   initial begin : divider_model
      logic [31:0] a_m, b_m, q_m, r_m;
      logic s_m;
      bit pend, fire, last_p;
      int cnt;
      pend = 0; fire = 0; last_p = 0; cnt = 0;
      a_m = 0; b_m = 0; q_m = 0; r_m = 0; s_m = 0;
      dif.div_done = 1'b0;
      dif.div_quot = 32'd0;
      dif.div_rem  = 32'd0;
      forever begin
         @(negedge clk);
         if (!cpurst_n) begin
            pend = 0; fire = 0; last_p = 0;
         end else begin
            if (pend) begin
               chk("hold_dividend", dif.dividend, a_m);
               chk("hold_divider", dif.divider, b_m);
               chk("hold_divsigned", 32'(dif.divsigned), 32'(s_m));
               cnt--;
               if (cnt <= 0) begin
                  fire = 1;
                  pend = 0;
               end
            end
            if (dif.diven_p) begin
               chk("single_pulse", 32'(last_p), 32'd0);
               a_m = dif.dividend;
               b_m = dif.divider;
               s_m = dif.divsigned;
               ref_divide(s_m, a_m, b_m, q_m, r_m);
               launch_cnt++;
               launch_signed = s_m;
               pend = 1;
               cnt = div_lat;
            end
            last_p = dif.diven_p;
         end
         @(posedge clk);
         #1;
         dif.div_done = fire;
         dif.div_quot = fire ? q_m : $urandom;
         dif.div_rem  = fire ? r_m : $urandom;
         fire = 0;
      end
   end

   initial begin : ready_driver
      dif.wb_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       dif.wb_ready = 1'b0;
            1:       dif.wb_ready = 1'b1;
            default: dif.wb_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   initial begin : monitor
      logic pv_valid, pv_ready, pv_flush, pv_done, pv_acc;
      logic [31:0] pv_data;
      logic [4:0] pv_rd;
      exp_t e;
      pv_valid = 0; pv_ready = 0; pv_flush = 0; pv_done = 0; pv_acc = 0;
      pv_data = 0; pv_rd = 0;
      forever begin
         @(negedge clk);
         if (!cpurst_n) begin
            pv_valid = 0; pv_done = 0; pv_acc = 0;
         end else begin
            chk("ex_ready_rule", 32'(dif.ex_ready), 32'(!dif.busy && !dif.flush));
            if (dif.wb_valid && !pv_valid) begin
`ifdef DIV_SPECIAL_BYPASS_EN
               chk("wb_latency", 32'(pv_done || pv_acc), 32'd1);
`else
               chk("wb_latency", 32'(pv_done), 32'd1);
`endif
            end
            if (pv_valid && !pv_ready && !pv_flush) begin
               chk("resp_hold_valid", 32'(dif.wb_valid), 32'd1);
               chk("resp_hold_data", dif.wb_data, pv_data);
               chk("resp_hold_rd", 32'(dif.wb_rd), 32'(pv_rd));
            end
            if (dif.wb_valid && dif.wb_ready && !dif.flush) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_wb: got data 0x%08h rd %0d, expected no result",
                           dif.wb_data, dif.wb_rd);
               end else begin
                  e = exp_q.pop_front();
                  chk("wb_data", dif.wb_data, e.data);
                  chk("wb_rd", 32'(dif.wb_rd), 32'(e.rd));
                  $display("wb rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                           dif.wb_rd, dif.wb_data, e.rd, e.data);
               end
            end
            pv_valid = dif.wb_valid;
            pv_ready = dif.wb_ready;
            pv_flush = dif.flush;
            pv_done  = dif.div_done;
            pv_acc   = dif.ex_valid && dif.ex_ready;
            pv_data  = dif.wb_data;
            pv_rd    = dif.wb_rd;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit keep);
      exp_t e;
      int t;
      @(posedge clk);
      #1;
      dif.ex_valid  = 1'b1;
      dif.ex_funct3 = f3;
      dif.ex_rs1    = a;
      dif.ex_rs2    = b;
      dif.ex_rd     = rd;
      t = 0;
      @(negedge clk);
      while (!dif.ex_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!dif.ex_ready) begin
         timeout_fail("accept");
      end else begin
         $display("issue f3=%0b rs1=0x%08h rs2=0x%08h rd=%0d keep=%0d", f3, a, b, rd, keep);
         if (keep) begin
            e.data = ref_result(f3, a, b);
            e.rd   = rd;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      dif.ex_valid = 1'b0;
      dif.ex_rs1   = $urandom;
      dif.ex_rs2   = $urandom;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (dif.busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (dif.busy) timeout_fail("wait_idle");
   endtask

   task automatic wait_launch();
      int t;
      t = 0;
      @(negedge clk);
      while (!dif.diven_p && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!dif.diven_p) timeout_fail("wait_launch");
   endtask

   task automatic wait_wbvalid();
      int t;
      t = 0;
      @(negedge clk);
      while (!dif.wb_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!dif.wb_valid) timeout_fail("wait_wbvalid");
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ex_ready"}, 32'(dif.ex_ready), 32'd1);
      chk({tag, "_diven_p"}, 32'(dif.diven_p), 32'd0);
      chk({tag, "_wb_valid"}, 32'(dif.wb_valid), 32'd0);
      chk({tag, "_busy"}, 32'(dif.busy), 32'd0);
      chk({tag, "_dividend"}, dif.dividend, 32'd0);
      chk({tag, "_divider"}, dif.divider, 32'd0);
      chk({tag, "_wb_data"}, dif.wb_data, 32'd0);
      chk({tag, "_wb_rd"}, 32'(dif.wb_rd), 32'd0);
      chk({tag, "_divsigned"}, 32'(dif.divsigned), 32'd0);
   endtask

   initial begin : main
      int l0;
      int cyc;
      logic [2:0] f3;
      dif.ex_valid  = 1'b0;
      dif.ex_funct3 = 3'b000;
      dif.ex_rs1    = 32'd0;
      dif.ex_rs2    = 32'd0;
      dif.ex_rd     = 5'd0;
      dif.flush     = 1'b0;

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      #1;
      cpurst_n = 1'b1;

      // Signed overflow case
      rdy_mode = 1;
      l0 = launch_cnt;
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b1);
      wait_idle();
`ifdef DIV_SPECIAL_BYPASS_EN
      chk("ovf_launches", 32'(launch_cnt - l0), 32'd0);
`else
      chk("ovf_launches", 32'(launch_cnt - l0), 32'd1);
      chk("ovf_divsigned", 32'(launch_signed), 32'd1);
`endif

      // REMU with a long divider latency: operands held through BUSY
      div_lat = 10;
      issue(3'b111, 32'd100, 32'd7, 5'd9, 1'b1);
      wait_idle();

      // Divide by zero
      div_lat = 2;
      issue(3'b101, 32'h1234, 32'd0, 5'd12, 1'b1);
      issue(3'b110, 32'h1234, 32'd0, 5'd13, 1'b1);
      wait_idle();

      // flush in IDLE blocks acceptance
      @(posedge clk);
      #1;
      dif.flush     = 1'b1;
      dif.ex_valid  = 1'b1;
      dif.ex_funct3 = 3'b101;
      dif.ex_rs1    = 32'd50;
      dif.ex_rs2    = 32'd5;
      @(negedge clk);
      chk("idle_flush_ex_ready", 32'(dif.ex_ready), 32'd0);
      @(posedge clk);
      #1;
      dif.flush    = 1'b0;
      dif.ex_valid = 1'b0;
      @(negedge clk);
      chk("idle_flush_no_accept", 32'(dif.busy), 32'd0);

      // flush one cycle after the launch pulse, divider finishes 33 cycles later
      div_lat = 33;
      issue(3'b100, 32'd1000, 32'd7, 5'd4, 1'b0);
      wait_launch();
      @(posedge clk);
      #1;
      dif.flush = 1'b1;
      @(posedge clk);
      #1;
      dif.flush = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (dif.busy && cyc < 100) begin
         chk("drain_no_wb_valid", 32'(dif.wb_valid), 32'd0);
         cyc++;
         @(negedge clk);
      end
      chk("drain_ex_ready_after", 32'(dif.ex_ready), 32'd1);
      chk("drain_busy_long", 32'(cyc >= 25), 32'd1);

      // Writeback back-pressure for several cycles
      div_lat = 3;
      rdy_mode = 0;
      issue(3'b101, 32'hDEAD_0000, 32'h100, 5'd7, 1'b1);
      wait_wbvalid();
      repeat (5) begin
         @(negedge clk);
         chk("resp_stall_valid", 32'(dif.wb_valid), 32'd1);
      end
      rdy_mode = 1;
      wait_idle();

      // flush in RESP with wb_ready high drops the result
      rdy_mode = 0;
      issue(3'b110, 32'd77, 32'd5, 5'd8, 1'b0);
      wait_wbvalid();
      rdy_mode = 1;
      @(posedge clk);
      #1;
      dif.flush = 1'b1;
      @(posedge clk);
      #1;
      dif.flush = 1'b0;
      @(negedge clk);
      chk("resp_flush_wb_valid", 32'(dif.wb_valid), 32'd0);
      chk("resp_flush_busy", 32'(dif.busy), 32'd0);

      // Asynchronous reset while the divider is running
      div_lat = 20;
      issue(3'b100, 32'd555, 32'd3, 5'd2, 1'b0);
      wait_launch();
      @(posedge clk);
      #3;
      cpurst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      @(negedge clk);
      #1;
      cpurst_n = 1'b1;
      div_lat = 5;
      issue(3'b100, 32'd20, 32'hFFFF_FFFD, 5'd11, 1'b1);
      wait_idle();

      // Randomized back-to-back traffic
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         div_lat = $urandom_range(1, 8);
         if ($urandom_range(0, 9) < 8) f3 = 3'(4 + $urandom_range(0, 3));
         else f3 = 3'($urandom_range(0, 3));
         issue(f3, pick_operand(), pick_operand(), 5'($urandom_range(0, 31)), 1'b1);
      end
      wait_idle();
      rdy_mode = 1;
      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Requester side of the iterative divider (divrem_top) handshake; sits in the EX stage next to the ALU.
- Accepts RISC-V M-extension DIV/DIVU/REM/REMU ops from decode and launches the divider with a one-cycle diven_p pulse and stable operands.
- Waits for the divider's completion, selects quotient or remainder, and presents the result to writeback with a valid/ready handshake.
- Stalls EX while busy and handles pipeline flush while a division is in flight.

Parameters:
XLEN, 32, operand/result width
RDW, 5, destination register index width

Ports:
clk  in  1  core clock
cpurst_n  in  1  asynchronous active-low reset
ex_valid  in  1  decode presents a div/rem op
ex_ready  out  1  op accepted this cycle when ex_valid&&ex_ready
ex_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU (others: treated as DIVU)
ex_rs1  in  XLEN  dividend operand
ex_rs2  in  XLEN  divisor operand
ex_rd  in  RDW  destination register
flush  in  1  kill in-flight op (branch/trap)
diven_p  out  1  one-cycle divider start pulse
dividend  out  XLEN  to divider, held stable from launch until div_done
divider  out  XLEN  divisor to divider, held stable likewise
divsigned  out  1  1 for DIV/REM
div_done  in  1  divider completion pulse (one cycle)
div_quot  in  XLEN  divider quotient, valid with div_done
div_rem  in  XLEN  divider remainder, valid with div_done
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts
wb_data  out  XLEN  quotient or remainder
wb_rd  out  RDW  destination register
busy  out  1  EX stall request, 1 in every state except IDLE

Behaviour:
- Reset (cpurst_n low, asynchronous): state IDLE. ex_ready=1; diven_p, wb_valid, busy=0; dividend, divider, wb_data=0; wb_rd=0; divsigned=0.
- All outputs are registered except ex_ready, which equals (state==IDLE)&&!flush.
- IDLE: on ex_valid&&ex_ready, latch rs1->dividend, rs2->divider, funct3[1]->sel_rem, !funct3[0]->divsigned, and ex_rd. Go to LAUNCH.
- LAUNCH: diven_p=1 for exactly this one cycle. Go to BUSY.
- BUSY: diven_p=0; operands are held. On div_done, capture div_rem if sel_rem, else div_quot, into wb_data. Go to RESP.
- RESP: wb_valid=1; wb_data and wb_rd are stable until wb_valid&&wb_ready. Then go to IDLE, and a new op can be accepted in the following cycle. Back-to-back throughput = divider latency + 3 cycles minimum.
- Latency (no bypass): accept at cycle N -> diven_p at N+1 -> wb_valid the cycle after div_done.
- flush in IDLE: nothing accepted (ex_ready=0).
- flush in LAUNCH: diven_p is still issued; go to DRAIN.
- flush in BUSY: go to DRAIN. If div_done arrives in the same cycle, discard the result and go to IDLE.
- flush in RESP: drop wb_valid the next cycle; go to IDLE. The result is lost even if wb_ready was high in the same cycle, because flush has priority.
- DRAIN: the divider cannot be aborted. Wait for div_done, discard it, go to IDLE. wb_valid stays 0; busy=1.
- A div_done seen in IDLE, LAUNCH or RESP is ignored.
- Reset mid-operation returns to IDLE immediately. Reset of the divider is the caller's concern.

Optional Feature:
- Macro: DIV_SPECIAL_BYPASS_EN.
- Defined: in IDLE on accept, the special cases are detected and the divider is not launched. The block goes straight to RESP, so wb_valid is asserted the cycle after accept.
  - Divisor==0: quotient = all ones (0xFFFFFFFF), remainder = rs1.
  - Signed op with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - diven_p stays 0 for these ops.
- Undefined: every op is launched on the divider, and its quotient/remainder is forwarded unmodified.

Test Plan:
- DIV rs1=0x80000000, rs2=0xFFFFFFFF (signed): without macro, diven_p pulses once with divsigned=1 and wb_data=div_quot from the model (0x80000000). With macro, no diven_p, and wb_valid with 0x80000000 one cycle after accept.
- REMU rs1=100, rs2=7, rd=9: dividend=100 and divider=7 are held stable through BUSY; wb_data=2 and wb_rd=9; ex_ready=0 until the handshake completes.
- DIVU rs2=0, rs1=0x1234: with macro, wb_data=0xFFFFFFFF. REM rs2=0, rs1=0x1234 -> wb_data=0x1234.
- flush one cycle after diven_p, then div_done 33 cycles later: no wb_valid; busy stays 1 until div_done; ex_ready returns the cycle after.
- wb_ready held 0 for 5 cycles in RESP: wb_valid and wb_data stay stable. flush asserted with wb_ready=1 in RESP: the result is dropped and state returns to IDLE.
- cpurst_n pulsed low during BUSY: all outputs return to reset values asynchronously. After release, an accepted DIV 20/-3 yields quotient 0xFFFFFFFA.
